and_array: RTL and testbench
============================

AND_ARRAY -- requirements
Module: and_array

Interface
REQ-001 Parameter NUM_INPUTS, default 4: width of the input literal vector, range 1..32.
REQ-002 Parameter SIZE, default 4: number of product terms (outputs), range 1..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_bits  input  NUM_INPUTS  input literals.
REQ-006 sel  input  SIZE*NUM_INPUTS  per-term select mask, flattened; term j mask = sel[j*NUM_INPUTS +: NUM_INPUTS].
REQ-007 sel_n  input  SIZE*NUM_INPUTS  per-term complement-literal mask, same packing as sel; present only when AND_ARRAY_COMPLEMENT_EN is defined.
REQ-008 out  output  SIZE  registered product-term results, bit j = term j.

Function
REQ-009 Term j combinational value SHALL be the AND of every in_bits[i] whose sel bit i for term j is 1; unselected inputs are don't-care.
REQ-010 A term whose total mask (sel, plus sel_n when compiled in) is all-zero SHALL evaluate to 0 (unprogrammed term disabled, not constant 1).
REQ-011 out[j] SHALL be registered: value at rising edge k reflects in_bits and sel sampled at edge k; latency exactly 1 cycle.
REQ-012 sel and sel_n SHALL be treated as live inputs every cycle; a mask change takes effect on the next rising edge, with no extra latency.
REQ-013 Terms SHALL be independent; any number of terms may share identical masks and produce identical outputs.
REQ-014 Example, NUM_INPUTS=3, SIZE=4, masks {1,2,3,4}: out[0]=in[0], out[1]=in[1], out[2]=in[0]&in[1], out[3]=in[2].
REQ-015 No X propagation from unselected inputs: a term's output SHALL depend only on selected bits.

Reset
REQ-016 While rst_n=0, out SHALL be all-zero, asserted asynchronously without waiting for clk.
REQ-017 Deassertion of rst_n SHALL take effect on the next rising clk edge; the first valid out appears on the first edge with rst_n=1.
REQ-018 Reset asserted mid-operation SHALL clear out immediately regardless of in_bits or masks.

Configuration
REQ-019 Macro AND_ARRAY_COMPLEMENT_EN: when defined, port sel_n exists and term j additionally ANDs ~in_bits[i] for every set sel_n bit i (PAL true/complement literals); a term with both sel and sel_n set for the same i SHALL evaluate to 0.
REQ-020 Without AND_ARRAY_COMPLEMENT_EN, port sel_n is absent and only true literals are used.

Structure
REQ-021 Package and_array_pkg SHALL hold default constants (NUM_INPUTS_DEF=4, SIZE_DEF=4, MAX_WIDTH=32) and a mask-slice helper function.
REQ-022 One sub-module and_term SHALL implement a single combinational product term (in_bits, mask, optional complement mask -> 1-bit result); and_array generates SIZE instances plus the output register.

Verification
REQ-023 NUM_INPUTS=3, SIZE=4, masks {1,2,3,4}, in_bits=3'b011 -> after one edge out=4'b0111; in_bits=3'b111 -> out=4'b1111.
REQ-024 Same config, in_bits=3'b100 -> out=4'b1000; in_bits=3'b000 -> out=4'b0000.
REQ-025 Term mask all-zero, in_bits all-ones -> that out bit = 0.
REQ-026 rst_n pulled low between clock edges with out=4'b1111 -> out=0 immediately; release -> correct value on first edge after release.
REQ-027 Change term 2 mask 3->4 while in_bits=3'b100 held -> out[2] goes 0->1 exactly one edge later.
REQ-028 With AND_ARRAY_COMPLEMENT_EN: term 0 sel=1, sel_n=2, in_bits=3'b001 -> out[0]=1; in_bits=3'b011 -> out[0]=0; sel=sel_n=1 -> out[0]=0 for all in_bits.

Source files
------------

// File: rtl/and_array_pkg.sv
// Shared constants and helpers for the programmable AND array.
// Optional feature macro: AND_ARRAY_COMPLEMENT_EN (adds complement literals).
package and_array_pkg;

    localparam int NUM_INPUTS_DEF = 4;
    localparam int SIZE_DEF       = 4;
    localparam int MAX_WIDTH      = 32;

    // Bit offset of term `term` inside a flattened per-term mask vector.
    function automatic int slice_base(input int term, input int width);
        return term * width;
    endfunction

endpackage

// File: rtl/and_term.sv
// One combinational product term: ANDs every selected true literal (and,
// when AND_ARRAY_COMPLEMENT_EN is defined, every selected complement
// literal). A term with an empty mask is disabled and returns 0.
module and_term #(
    parameter int NUM_INPUTS = 4
) (
    input  logic [NUM_INPUTS-1:0] in_bits,
    input  logic [NUM_INPUTS-1:0] mask,
`ifdef AND_ARRAY_COMPLEMENT_EN
    input  logic [NUM_INPUTS-1:0] mask_n,
`endif
    output logic                  result
);

    logic any_sel;
    logic true_and;
    logic comp_and;

    // Unselected bits are forced to 1 before the reduction, so an X on an
    // unselected input can never reach the result.
    assign true_and = &(in_bits | ~mask);

`ifdef AND_ARRAY_COMPLEMENT_EN
    assign comp_and = &(~in_bits | ~mask_n);
    assign any_sel  = |{mask, mask_n};
`else
    assign comp_and = 1'b1;
    assign any_sel  = |mask;
`endif

    assign result = any_sel & true_and & comp_and;

endmodule

// File: rtl/and_array.sv
// Programmable AND plane: SIZE independent product terms over NUM_INPUTS
// literals, each result registered with one cycle of latency.
// Optional feature macro: AND_ARRAY_COMPLEMENT_EN (adds port sel_n).
module and_array
    import and_array_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int SIZE       = SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_INPUTS-1:0]      in_bits,
    input  logic [SIZE*NUM_INPUTS-1:0] sel,
`ifdef AND_ARRAY_COMPLEMENT_EN
    input  logic [SIZE*NUM_INPUTS-1:0] sel_n,
`endif
    output logic [SIZE-1:0]            out
);

    logic [SIZE-1:0] term_val;

    for (genvar j = 0; j < SIZE; j++) begin : g_term
        and_term #(
            .NUM_INPUTS(NUM_INPUTS)
        ) u_term (
            .in_bits(in_bits),
            .mask   (sel[slice_base(j, NUM_INPUTS) +: NUM_INPUTS]),
`ifdef AND_ARRAY_COMPLEMENT_EN
            .mask_n (sel_n[slice_base(j, NUM_INPUTS) +: NUM_INPUTS]),
`endif
            .result (term_val[j])
        );
    end

    // Register all term results; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every flop sampling the pre-edge value.
            out <= term_val;
        end
    end

endmodule

// File: tb/tb_and_array.sv
// Self-checking bench for and_array with NUM_INPUTS=3, SIZE=4.
// Complement-literal vectors run only when AND_ARRAY_COMPLEMENT_EN is defined.
module tb_and_array;

    localparam int NI = 3;
    localparam int SZ = 4;

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] in_bits;
    logic [SZ*NI-1:0] sel;
    logic [SZ*NI-1:0] sel_n;
    logic [SZ-1:0] out;

    logic [SZ-1:0] exp_q = '0;
    logic          started = 1'b0;
    int            checks = 0;
    int            errors = 0;

    and_array #(
        .NUM_INPUTS(NI),
        .SIZE      (SZ)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_bits(in_bits),
        .sel    (sel),
`ifdef AND_ARRAY_COMPLEMENT_EN
        .sel_n  (sel_n),
`endif
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural term evaluation: walk each term's literal list directly.
    function automatic logic [SZ-1:0] model(input logic [NI-1:0] x,
                                            input logic [SZ*NI-1:0] s,
                                            input logic [SZ*NI-1:0] sn);
        logic [SZ-1:0] r;
        r = '0;
        for (int j = 0; j < SZ; j++) begin
            int  nlit;
            logic v;
            nlit = 0;
            v    = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (s[j*NI+i]) begin
                    nlit++;
                    v = v & x[i];
                end
`ifdef AND_ARRAY_COMPLEMENT_EN
                if (sn[j*NI+i]) begin
                    nlit++;
                    v = v & ~x[i];
                end
`endif
            end
            r[j] = (nlit > 0) ? v : 1'b0;
        end
        return r;
    endfunction

    // Expected registered output: one-edge delay of the model, async clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= model(in_bits, sel, sel_n);
    end

    task automatic check(input string name, input logic [SZ-1:0] act,
                         input logic [SZ-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: out=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) check("model", out, exp_q);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SZ*NI-1:0] masks(input logic [NI-1:0] m3, input logic [NI-1:0] m2,
                                               input logic [NI-1:0] m1, input logic [NI-1:0] m0);
        return {m3, m2, m1, m0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: out=%b required=finish", out);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        in_bits = 3'b111;
        sel     = masks(3'd4, 3'd3, 3'd2, 3'd1);
        sel_n   = '0;

        // Reset holds output low even with every term satisfied.
        step();
        started = 1'b1;
        check("reset_state", out, 4'b0000);

        // First edge with rst_n high produces the first valid result.
        rst_n   = 1'b1;
        in_bits = 3'b011;
        step();
        check("ex_011", out, 4'b0111);
        in_bits = 3'b111;
        step();
        check("ex_111", out, 4'b1111);
        in_bits = 3'b100;
        step();
        check("ex_100", out, 4'b1000);
        in_bits = 3'b000;
        step();
        check("ex_000", out, 4'b0000);

        // Empty mask on term 1 disables it despite all-ones inputs.
        sel     = masks(3'd4, 3'd3, 3'd0, 3'd1);
        in_bits = 3'b111;
        step();
        check("empty_mask", out, 4'b1101);

        // Mid-cycle asynchronous reset, then release.
        sel = masks(3'd4, 3'd3, 3'd2, 3'd1);
        step();
        check("pre_reset", out, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 4'b0000);
        step();
        check("held_reset", out, 4'b0000);
        rst_n   = 1'b1;
        in_bits = 3'b011;
        step();
        check("post_release", out, 4'b0111);

        // Live mask change takes effect exactly one edge later.
        in_bits = 3'b100;
        step();
        check("mask_before", out, 4'b1000);
        sel = masks(3'd4, 3'd4, 3'd2, 3'd1);
        #1;
        check("mask_no_early", out, 4'b1000);
        step();
        check("mask_after", out, 4'b1100);

        // Identical masks give identical outputs.
        sel     = masks(3'd5, 3'd5, 3'd5, 3'd5);
        in_bits = 3'b101;
        step();
        check("shared_hit", out, 4'b1111);
        in_bits = 3'b100;
        step();
        check("shared_miss", out, 4'b0000);

        // Full-width mask.
        sel     = masks(3'd7, 3'd7, 3'd7, 3'd7);
        in_bits = 3'b111;
        step();
        check("full_hit", out, 4'b1111);
        in_bits = 3'b110;
        step();
        check("full_miss", out, 4'b0000);

        // Unknown on an unselected input must not leak into any term.
        sel     = masks(3'd3, 3'd3, 3'd2, 3'd1);
        in_bits = 3'bx11;
        step();
        check("x_unselected", out, 4'b1111);

`ifdef AND_ARRAY_COMPLEMENT_EN
        // Term 0: in[0] & ~in[1]; other terms disabled.
        sel     = masks(3'd0, 3'd0, 3'd0, 3'd1);
        sel_n   = masks(3'd0, 3'd0, 3'd0, 3'd2);
        in_bits = 3'b001;
        step();
        check("comp_hit", out, 4'b0001);
        in_bits = 3'b011;
        step();
        check("comp_miss", out, 4'b0000);
        // Same literal in both polarities can never be true.
        sel_n = masks(3'd0, 3'd0, 3'd0, 3'd1);
        for (int v = 0; v < 8; v++) begin
            in_bits = NI'(v);
            step();
            check("comp_conflict", out, 4'b0000);
        end
        sel_n = '0;
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
